// File: rtl/penta_pkg.sv
// Shared definitions for the pentary (base-5) datapath: digit format, radix and
// the serial converter FSM states. Also used by the downstream pentary adder chain.
package penta_pkg;

    localparam int DIGIT_W = 3;
    localparam int BASE    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        EMIT = 2'd2
    } state_e;

    typedef logic [DIGIT_W-1:0] digit_t;

    // BASE raised to the n-th power, evaluated at elaboration time for range checks
    function automatic longint pow_base(input int n);
        longint r;
        r = 64'sd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'(BASE);
        end
        return r;
    endfunction

endpackage

// File: rtl/penta_divstep.sv
// One restoring division step by 5: shifts the next dividend bit into the
// partial remainder and subtracts 5 when it fits. rem_i must be 0..4, so the
// shifted value is 0..9 and the result remainder is again 0..4.
module penta_divstep
    import penta_pkg::*;
(
    input  logic [DIGIT_W-1:0] rem_i,
    input  logic               bit_i,
    output logic [DIGIT_W-1:0] rem_o,
    output logic               q_o
);

    localparam logic [DIGIT_W:0]   BASE_W = (DIGIT_W+1)'(BASE);
    localparam logic [DIGIT_W-1:0] BASE_N = DIGIT_W'(BASE);

    logic [DIGIT_W:0] t_s;

    // Compare-and-subtract; the difference is below 8 so the low bits alone are exact
    always_comb begin
        t_s = {rem_i, bit_i};
        if (t_s >= BASE_W) begin
            rem_o = t_s[DIGIT_W-1:0] - BASE_N;
            q_o   = 1'b1;
        end else begin
            rem_o = t_s[DIGIT_W-1:0];
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/bin2penta_serial.sv
// Serial binary -> base-5 converter. Each accepted word is divided by 5 NDIG
// times with a bit-serial restoring divider; every remainder is emitted as one
// digit (LSD first) through a valid/ready handshake. All outputs are registers.
module bin2penta_serial
    import penta_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIGIT_W-1:0] out_digit,
    output logic               out_last,
    output logic               busy
);

    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DC_W = (NDIG  > 1) ? $clog2(NDIG)  : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WIDTH - 1);
    localparam logic [DC_W-1:0] DIG_LAST = DC_W'(NDIG - 1);
    localparam longint MAX_IN = (64'sd1 <<< WIDTH) - 64'sd1;

    // NDIG digits must be able to represent every WIDTH-bit value
    if (pow_base(NDIG) <= MAX_IN) begin : g_bad_ndig
        $error("bin2penta_serial: 5**NDIG must exceed 2**WIDTH-1");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   val_q;
    logic [WIDTH-1:0]   q_q;
    logic [DIGIT_W-1:0] rem_q;
    logic [BC_W-1:0]    bit_cnt_q;
    logic [DC_W-1:0]    dig_cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [DIGIT_W-1:0] out_digit_q;
    logic               out_last_q;
    logic               busy_q;

    logic [DIGIT_W-1:0] rem_d;
    logic               q_bit_d;

    // val_q is consumed MSB first by shifting left, so its top bit is always the next dividend bit
    penta_divstep u_divstep (
        .rem_i (rem_q),
        .bit_i (val_q[WIDTH-1]),
        .rem_o (rem_d),
        .q_o   (q_bit_d)
    );

    // Control FSM, divider work registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            val_q       <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            bit_cnt_q   <= '0;
            dig_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        val_q      <= in_data;
                        q_q        <= '0;
                        rem_q      <= '0;
                        bit_cnt_q  <= BIT_LAST;
                        dig_cnt_q  <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= DIV;
                    end
                end
                DIV: begin
                    val_q <= val_q << 1;
                    q_q   <= {q_q[WIDTH-2:0], q_bit_d};
                    rem_q <= rem_d;
                    if (bit_cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        out_digit_q <= rem_d;
                        out_last_q  <= (dig_cnt_q == DIG_LAST);
                        state_q     <= EMIT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            val_q     <= q_q;
                            q_q       <= '0;
                            rem_q     <= '0;
                            bit_cnt_q <= BIT_LAST;
                            dig_cnt_q <= dig_cnt_q + 1'b1;
                            state_q   <= DIV;
                        end
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bin2penta_serial.sv
// Directed bench for bin2penta_serial (WIDTH=8, NDIG=4). Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_bin2penta_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_digit;
    logic       out_last;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    bin2penta_serial #(.WIDTH(8), .NDIG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Offer one word at the current falling edge; returns one falling edge after acceptance
    task automatic send_word(input logic [7:0] v, output bit to);
        int c;
        c  = 0;
        to = 1'b0;
        while (!in_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (!in_ready) begin
            to = 1'b1;
        end else begin
            in_valid = 1'b1;
            in_data  = v;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Collect four digits with out_ready high; digs = {d3,d2,d1,d0}; cycle counts from call
    task automatic get_digits(output logic [11:0] digs, output logic [3:0] lasts,
                              output int first_c, output int last_c,
                              output bit rdy_hi, output bit to);
        int cnt;
        int k;
        cnt = 0; k = 0; first_c = -1; last_c = -1;
        digs = '0; lasts = '0; rdy_hi = 1'b0; to = 1'b0;
        out_ready = 1'b1;
        while (k < 4 && cnt < 200) begin
            if (in_ready) rdy_hi = 1'b1;
            if (out_valid) begin
                digs[k*3 +: 3] = out_digit;
                lasts[k]       = out_last;
                if (k == 0) first_c = cnt;
                if (k == 3) last_c = cnt;
                k++;
            end
            @(negedge clk);
            cnt++;
        end
        if (k < 4) to = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_digit !== 3'd0) begin n_err++; $display("FAIL reset_out_digit: got %0d want 0", out_digit); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: in_ready=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    task automatic test_zero();
        logic [11:0] d; logic [3:0] l; int f, la; bit rh, to;
        send_word(8'd0, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL zero_accept: got timeout want accept"); end
        get_digits(d, l, f, la, rh, to);
        n_cmp++; if (to || d !== 12'h000) begin n_err++; $display("FAIL zero_digits: got %h (to=%0d) want 000", d, to); end
        n_cmp++; if (l !== 4'b1000) begin n_err++; $display("FAIL zero_last: got %b want 1000", l); end
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_idle: in_ready=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    task automatic test_latency_255();
        logic [11:0] d; logic [3:0] l; int f, la; bit rh, to;
        send_word(8'd255, to);
        n_cmp++; if (to || busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL b255_busy: busy=%b in_ready=%b to=%0d want 1/0/0", busy, in_ready, to); end
        get_digits(d, l, f, la, rh, to);
        n_cmp++; if (to || d !== {3'd2, 3'd0, 3'd1, 3'd0}) begin n_err++; $display("FAIL b255_digits: got %h want %h", d, {3'd2, 3'd0, 3'd1, 3'd0}); end
        n_cmp++; if (f !== 8) begin n_err++; $display("FAIL b255_first_latency: got %0d want 8", f); end
        n_cmp++; if (la !== 35) begin n_err++; $display("FAIL b255_last_digit_cycle: got %0d want 35", la); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b255_idle_at_36: in_ready=%b want 1", in_ready); end
        n_cmp++; if (rh !== 1'b0) begin n_err++; $display("FAIL b255_ready_low: in_ready seen high=%b want 0", rh); end
    endtask

    task automatic test_vectors();
        logic [7:0]  vin [2];
        logic [11:0] vexp [2];
        logic [11:0] d; logic [3:0] l; int f, la; bit rh, to;
        vin[0] = 8'd124; vexp[0] = {3'd0, 3'd4, 3'd4, 3'd4};
        vin[1] = 8'd5;   vexp[1] = {3'd0, 3'd0, 3'd1, 3'd0};
        for (int i = 0; i < 2; i++) begin
            send_word(vin[i], to);
            get_digits(d, l, f, la, rh, to);
            n_cmp++; if (to || d !== vexp[i] || l !== 4'b1000) begin n_err++; $display("FAIL vec_%0d: got %h/%b want %h/1000", vin[i], d, l, vexp[i]); end
        end
    endtask

    task automatic test_exhaustive();
        logic [11:0] d; logic [3:0] l; int f, la; bit rh, to;
        int recon, pw; bit bad_dig;
        for (int v = 0; v < 256; v++) begin
            send_word(8'(v), to);
            get_digits(d, l, f, la, rh, to);
            recon = 0; pw = 1; bad_dig = 1'b0;
            for (int i = 0; i < 4; i++) begin
                recon = recon + int'(d[i*3 +: 3]) * pw;
                pw = pw * 5;
                if (d[i*3 +: 3] > 3'd4) bad_dig = 1'b1;
            end
            n_cmp++; if (to || recon != v || l !== 4'b1000) begin n_err++; $display("FAIL exh_value: in=%0d got %0d last=%b want %0d/1000", v, recon, l, v); end
            n_cmp++; if (bad_dig) begin n_err++; $display("FAIL exh_range: in=%0d digits %h contain value above 4", v, d); end
        end
    endtask

    task automatic test_stall();
        logic [11:0] d; logic [3:0] l; int k, cnt; bit to;
        send_word(8'd199, to);
        d = '0; l = '0; k = 0; cnt = 0;
        out_ready = 1'b1;
        while (k < 4 && cnt < 300) begin
            if (out_valid) begin
                if (k == 2) begin
                    out_ready = 1'b0;
                    for (int s = 0; s < 3; s++) begin
                        @(negedge clk);
                        cnt++;
                        n_cmp++;
                        if (out_valid !== 1'b1 || out_digit !== 3'd2 || out_last !== 1'b0) begin
                            n_err++;
                            $display("FAIL stall_hold_%0d: got v=%b d=%0d l=%b want 1/2/0", s, out_valid, out_digit, out_last);
                        end
                    end
                    out_ready = 1'b1;
                end
                d[k*3 +: 3] = out_digit;
                l[k]        = out_last;
                k++;
            end
            @(negedge clk);
            cnt++;
        end
        n_cmp++; if (k != 4 || d !== {3'd1, 3'd2, 3'd4, 3'd4} || l !== 4'b1000) begin n_err++; $display("FAIL stall_stream: got %h/%b want %h/1000", d, l, {3'd1, 3'd2, 3'd4, 3'd4}); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] d; logic [3:0] l; int f, la, c; bit rh, to;
        send_word(8'd100, to);
        out_ready = 1'b1;
        c = 0;
        while (!out_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        n_cmp++; if (!out_valid) begin n_err++; $display("FAIL rstmid_first_digit: got no digit want out_valid=1"); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_abort: v=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(8'd17, to);
        get_digits(d, l, f, la, rh, to);
        n_cmp++; if (to || d !== {3'd0, 3'd0, 3'd3, 3'd2} || l !== 4'b1000) begin n_err++; $display("FAIL rstmid_next17: got %h/%b want %h/1000", d, l, {3'd0, 3'd0, 3'd3, 3'd2}); end
        n_cmp++; if (f !== 8) begin n_err++; $display("FAIL rstmid_latency: got %0d want 8", f); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] d; logic [3:0] l; int f, la; bit rh, to;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_start_ready: got %b want 1", in_ready); end
        in_valid = 1'b1;
        in_data  = 8'd7;
        @(negedge clk);
        in_data  = 8'd8;
        get_digits(d, l, f, la, rh, to);
        n_cmp++; if (to || d !== {3'd0, 3'd0, 3'd1, 3'd2} || l !== 4'b1000) begin n_err++; $display("FAIL b2b_word7: got %h/%b want %h/1000", d, l, {3'd0, 3'd0, 3'd1, 3'd2}); end
        n_cmp++; if (rh !== 1'b0) begin n_err++; $display("FAIL b2b_ready_low: in_ready seen high=%b want 0", rh); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: busy=%b want 1", busy); end
        get_digits(d, l, f, la, rh, to);
        n_cmp++; if (to || d !== {3'd0, 3'd0, 3'd1, 3'd3} || l !== 4'b1000) begin n_err++; $display("FAIL b2b_word8: got %h/%b want %h/1000", d, l, {3'd0, 3'd0, 3'd1, 3'd3}); end
        n_cmp++; if (f !== 8) begin n_err++; $display("FAIL b2b_word8_latency: got %0d want 8", f); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_latency_255();
        test_vectors();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
